// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the parametrised memory-access stage.
// Holds the default widths, the FSM encoding and the control bundle with its bubble value.
package mem_stage_pkg;

    localparam int DEF_DW  = 16;
    localparam int DEF_AW  = 8;
    localparam int DEF_RW  = 4;
    localparam int DEF_LAT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic mem_byte;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{default: 1'b0};

endpackage

// File: rtl/mem_stage_param_if.sv
// Execute-to-memory-stage bus: E-side controls and data in, M-side results and stall out.
// The master drives the E side; the stage itself is the slave.
interface mem_stage_param_if #(
    parameter int DW = mem_stage_pkg::DEF_DW,
    parameter int RW = mem_stage_pkg::DEF_RW
);
    logic          FlushM;
    logic          RegWriteE;
    logic          MemtoRegE;
    logic          MemWriteE;
    logic          MemByteE;
    logic [DW-1:0] ALUOutE;
    logic [DW-1:0] WriteDataE;
    logic [RW-1:0] WriteRegE;
    logic          RegWriteM;
    logic          MemtoRegM;
    logic [DW-1:0] ALUOutM;
    logic [RW-1:0] WriteRegM;
    logic [DW-1:0] RD;
    logic          StallM;

    modport master (
        output FlushM, RegWriteE, MemtoRegE, MemWriteE, MemByteE, ALUOutE, WriteDataE, WriteRegE,
        input  RegWriteM, MemtoRegM, ALUOutM, WriteRegM, RD, StallM
    );

    modport slave (
        input  FlushM, RegWriteE, MemtoRegE, MemWriteE, MemByteE, ALUOutE, WriteDataE, WriteRegE,
        output RegWriteM, MemtoRegM, ALUOutM, WriteRegM, RD, StallM
    );
endinterface

// File: rtl/mem_pipeline_reg_param.sv
// M pipeline register: synchronous active-low reset, stall has priority over flush.
// A flush loads the all-zero bubble into every field.
module mem_pipeline_reg_param
    import mem_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  ctrl_t         ctrl_e,
    input  logic [DW-1:0] alu_out_e,
    input  logic [DW-1:0] write_data_e,
    input  logic [RW-1:0] write_reg_e,
    output ctrl_t         ctrl_m,
    output logic [DW-1:0] alu_out_m,
    output logic [DW-1:0] write_data_m,
    output logic [RW-1:0] write_reg_m
);

    ctrl_t         ctrl_d,       ctrl_q;
    logic [DW-1:0] alu_out_d,    alu_out_q;
    logic [DW-1:0] write_data_d, write_data_q;
    logic [RW-1:0] write_reg_d,  write_reg_q;

    always_comb begin
        // NOTE: every output gets its hold value first so no path can infer a latch.
        ctrl_d       = ctrl_q;
        alu_out_d    = alu_out_q;
        write_data_d = write_data_q;
        write_reg_d  = write_reg_q;
        if (!stall) begin
            if (flush) begin
                ctrl_d       = CTRL_BUBBLE;
                alu_out_d    = '0;
                write_data_d = '0;
                write_reg_d  = '0;
            end else begin
                ctrl_d       = ctrl_e;
                alu_out_d    = alu_out_e;
                write_data_d = write_data_e;
                write_reg_d  = write_reg_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            ctrl_q       <= CTRL_BUBBLE;
            alu_out_q    <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            alu_out_q    <= alu_out_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
        end
    end

    assign ctrl_m       = ctrl_q;
    assign alu_out_m    = alu_out_q;
    assign write_data_m = write_data_q;
    assign write_reg_m  = write_reg_q;

endmodule

// File: rtl/mem_stage_param.sv
// Memory-access stage: M register, multi-cycle data memory with optional byte lanes,
// and a small counter FSM that stalls the pipeline for LAT-1 cycles per access.
module mem_stage_param
    import mem_stage_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int RW      = DEF_RW,
    parameter int LAT     = DEF_LAT,
    parameter int BYTE_EN = 1
) (
    input logic              CLK,
    input logic              RST_N,
    mem_stage_param_if.slave bus
);

    localparam int             HB       = DW / 2;
    localparam int             CW       = $clog2(LAT) + 1;
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(LAT - 1);

    ctrl_t         ctrl_e, ctrl_m;
    logic [DW-1:0] alu_out_m, write_data_m;
    logic [RW-1:0] write_reg_m;
    logic          stall, access, final_cycle, mem_we;
    state_e        state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;

    assign ctrl_e = '{reg_write:  bus.RegWriteE,
                      mem_to_reg: bus.MemtoRegE,
                      mem_write:  bus.MemWriteE,
                      mem_byte:   (BYTE_EN != 0) && bus.MemByteE};

    mem_pipeline_reg_param #(.DW(DW), .RW(RW)) u_mreg (
        .clk          (CLK),
        .rst_n        (RST_N),
        .stall        (stall),
        .flush        (bus.FlushM),
        .ctrl_e       (ctrl_e),
        .alu_out_e    (bus.ALUOutE),
        .write_data_e (bus.WriteDataE),
        .write_reg_e  (bus.WriteRegE),
        .ctrl_m       (ctrl_m),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .write_reg_m  (write_reg_m)
    );

    assign access = ctrl_m.mem_to_reg | ctrl_m.mem_write;

    // The first access cycle stalls from IDLE; the last one is the BUSY cycle at cnt == LAT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && (LAT > 1)) begin
                    stall   = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q < CNT_LAST) begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign final_cycle = access & ~stall;

    logic [AW-1:0] word_addr;
    logic          lane_hi;
    logic          unused_addr_bits;

    if (BYTE_EN != 0) begin : g_byte_addr
        assign word_addr = alu_out_m[AW:1];
        assign lane_hi   = alu_out_m[0];
    end else begin : g_word_addr
        assign word_addr = alu_out_m[AW-1:0];
        assign lane_hi   = 1'b0;
    end
    assign unused_addr_bits = ^alu_out_m;

    logic [DW-1:0] mem_array [0:(2**AW)-1];

    // A reset edge landing on the final cycle still aborts the store.
    assign mem_we = final_cycle & ctrl_m.mem_write & RST_N;

    // NOTE: the storage array carries no reset; its contents survive RST_N by design.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            if (ctrl_m.mem_byte) begin
                if (lane_hi) mem_array[word_addr][DW-1:HB] <= write_data_m[HB-1:0];
                else         mem_array[word_addr][HB-1:0]  <= write_data_m[HB-1:0];
            end else begin
                mem_array[word_addr] <= write_data_m;
            end
        end
    end

    logic [DW-1:0] rd_word, rd;

    always_comb begin
        rd_word = mem_array[word_addr];
        rd      = '0;
        if (ctrl_m.mem_to_reg && !stall) begin
            if (ctrl_m.mem_byte) rd = DW'(lane_hi ? rd_word[DW-1:HB] : rd_word[HB-1:0]);
            else                 rd = rd_word;
        end
    end

    assign bus.RegWriteM = ctrl_m.reg_write;
    assign bus.MemtoRegM = ctrl_m.mem_to_reg;
    assign bus.ALUOutM   = alu_out_m;
    assign bus.WriteRegM = write_reg_m;
    assign bus.RD        = rd;
    assign bus.StallM    = stall;

endmodule

// File: tb/tb_mem_stage_param.sv
// Directed bench for mem_stage_param: one LAT=2 byte-enabled instance and one LAT=4 instance
// sharing clock and reset, each scenario task checking its own hand-computed expectations.
module tb_mem_stage_param;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_param_if #(.DW(16), .RW(4)) if2 ();
    mem_stage_param_if #(.DW(16), .RW(4)) if4 ();

    mem_stage_param #(.DW(16), .AW(8), .RW(4), .LAT(2), .BYTE_EN(1)) dut2 (
        .CLK (clk), .RST_N (rst_n), .bus (if2.slave)
    );
    mem_stage_param #(.DW(16), .AW(8), .RW(4), .LAT(4), .BYTE_EN(1)) dut4 (
        .CLK (clk), .RST_N (rst_n), .bus (if4.slave)
    );

    task automatic set_e(input bit u4, input logic rw, m2r, mw, mb,
                         input logic [15:0] alu, wd, input logic [3:0] wr);
        if (u4) begin
            if4.RegWriteE = rw; if4.MemtoRegE = m2r; if4.MemWriteE = mw; if4.MemByteE = mb;
            if4.ALUOutE = alu;  if4.WriteDataE = wd; if4.WriteRegE = wr;
        end else begin
            if2.RegWriteE = rw; if2.MemtoRegE = m2r; if2.MemWriteE = mw; if2.MemByteE = mb;
            if2.ALUOutE = alu;  if2.WriteDataE = wd; if2.WriteRegE = wr;
        end
    endtask

    // Presents one E-side op, then follows it to its final cycle (returns at that cycle's negedge).
    task automatic access(input bit u4, input logic rw, m2r, mw, mb,
                          input logic [15:0] alu, wd, input logic [3:0] wr,
                          output int stalls, output logic [15:0] rd_first, rd_final);
        set_e(u4, rw, m2r, mw, mb, alu, wd, wr);
        @(negedge clk);
        set_e(u4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        stalls   = 0;
        rd_first = u4 ? if4.RD : if2.RD;
        while ((u4 ? if4.StallM : if2.StallM) === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL access_timeout: StallM still high after %0d cycles, want low within 20", stalls);
        end
        rd_final = u4 ? if4.RD : if2.RD;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if2.FlushM = 1'b0; if4.FlushM = 1'b0;
        set_e(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0, 4'h3);
        set_e(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0, 4'h3);
        repeat (2) @(negedge clk);
        n_tests++; if (if2.RegWriteM !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", if2.RegWriteM); end
        n_tests++; if (if2.MemtoRegM !== 1'b0) begin n_fail++; $display("FAIL reset_memtoreg: got %b want 0", if2.MemtoRegM); end
        n_tests++; if (if2.ALUOutM !== 16'h0) begin n_fail++; $display("FAIL reset_aluout: got %h want 0000", if2.ALUOutM); end
        n_tests++; if (if2.WriteRegM !== 4'h0) begin n_fail++; $display("FAIL reset_writereg: got %h want 0", if2.WriteRegM); end
        n_tests++; if (if2.RD !== 16'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 0000", if2.RD); end
        n_tests++; if (if2.StallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", if2.StallM); end
        n_tests++; if (if4.ALUOutM !== 16'h0 || if4.StallM !== 1'b0) begin
            n_fail++; $display("FAIL reset_lat4: got alu=%h stall=%b want 0000/0", if4.ALUOutM, if4.StallM);
        end
        rst_n = 1'b1;
        set_e(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        set_e(1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
    endtask

    task automatic test_word();
        int st; logic [15:0] rf, rl;
        access(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 4'h0, st, rf, rl);
        n_tests++; if (st != 1) begin n_fail++; $display("FAIL word_store_stall: got %0d want 1", st); end
        access(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 4'h3, st, rf, rl);
        n_tests++; if (st != 1) begin n_fail++; $display("FAIL word_load_stall: got %0d want 1", st); end
        n_tests++; if (rf !== 16'h0000) begin n_fail++; $display("FAIL word_load_rd_stall: got %h want 0000", rf); end
        n_tests++; if (rl !== 16'hBEEF) begin n_fail++; $display("FAIL word_load_rd: got %h want BEEF", rl); end
        n_tests++; if (if2.WriteRegM !== 4'h3 || if2.RegWriteM !== 1'b1) begin
            n_fail++; $display("FAIL word_load_ctrl: got wr=%h rw=%b want 3/1", if2.WriteRegM, if2.RegWriteM);
        end
        access(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0210, 16'h0, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'hBEEF) begin n_fail++; $display("FAIL addr_wrap: got %h want BEEF", rl); end
        @(negedge clk);
        n_tests++; if (if2.RD !== 16'h0) begin n_fail++; $display("FAIL rd_idle: got %h want 0000", if2.RD); end
    endtask

    task automatic test_byte();
        int st; logic [15:0] rf, rl;
        access(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234, 4'h0, st, rf, rl);
        access(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0021, 16'h00AB, 4'h0, st, rf, rl);
        access(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'hAB34) begin n_fail++; $display("FAIL byte_store_hi: got %h want AB34", rl); end
        access(0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'h0034) begin n_fail++; $display("FAIL byte_load_lo: got %h want 0034", rl); end
        access(0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0021, 16'h0, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'h00AB) begin n_fail++; $display("FAIL byte_load_hi: got %h want 00AB", rl); end
        access(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h99CD, 4'h0, st, rf, rl);
        access(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0021, 16'h0, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'hABCD) begin n_fail++; $display("FAIL byte_store_lo: got %h want ABCD", rl); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        if2.FlushM = 1'b1;
        set_e(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0099, 16'h0, 4'h5);
        @(negedge clk);
        n_tests++; if (if2.RegWriteM !== 1'b0 || if2.WriteRegM !== 4'h0) begin
            n_fail++; $display("FAIL flush_bubble: got rw=%b wr=%h want 0/0", if2.RegWriteM, if2.WriteRegM);
        end
        if2.FlushM = 1'b0;
        @(negedge clk);
        n_tests++; if (if2.RegWriteM !== 1'b1 || if2.WriteRegM !== 4'h5 || if2.ALUOutM !== 16'h0099) begin
            n_fail++; $display("FAIL pass_through: got rw=%b wr=%h alu=%h want 1/5/0099", if2.RegWriteM, if2.WriteRegM, if2.ALUOutM);
        end
        set_e(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 4'h6);
        @(negedge clk);
        n_tests++; if (if2.StallM !== 1'b1) begin n_fail++; $display("FAIL flush_stall_pre: got %b want 1", if2.StallM); end
        if2.FlushM = 1'b1;
        set_e(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0077, 16'h0, 4'h9);
        @(negedge clk);
        n_tests++; if (if2.StallM !== 1'b0 || if2.RD !== 16'hBEEF || if2.MemtoRegM !== 1'b1) begin
            n_fail++; $display("FAIL flush_in_stall: got stall=%b rd=%h m2r=%b want 0/BEEF/1", if2.StallM, if2.RD, if2.MemtoRegM);
        end
        n_tests++; if (if2.ALUOutM !== 16'h0010 || if2.WriteRegM !== 4'h6) begin
            n_fail++; $display("FAIL stall_hold: got alu=%h wr=%h want 0010/6", if2.ALUOutM, if2.WriteRegM);
        end
        if2.FlushM = 1'b0;
        set_e(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int st; logic [15:0] rf, rl;
        access(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h1111, 4'h0, st, rf, rl);
        @(negedge clk);
        set_e(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h5555, 4'h0);
        @(negedge clk);
        set_e(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        n_tests++; if (if2.StallM !== 1'b1) begin n_fail++; $display("FAIL midreset_stall_pre: got %b want 1", if2.StallM); end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (if2.StallM !== 1'b0 || if2.ALUOutM !== 16'h0) begin
            n_fail++; $display("FAIL midreset_state: got stall=%b alu=%h want 0/0000", if2.StallM, if2.ALUOutM);
        end
        rst_n = 1'b1;
        @(negedge clk);
        access(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'h1111) begin n_fail++; $display("FAIL midreset_no_write: got %h want 1111", rl); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int st; logic [15:0] rf, rl;
        access(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h2222, 4'h0, st, rf, rl);
        access(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h7777, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'h2222) begin n_fail++; $display("FAIL illegal_rd_old: got %h want 2222", rl); end
        access(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'h7777) begin n_fail++; $display("FAIL illegal_written: got %h want 7777", rl); end
        @(negedge clk);
    endtask

    task automatic test_lat4();
        int st; logic [15:0] rf, rl;
        set_e(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0, 4'h7);
        @(negedge clk);
        set_e(1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        n_tests++; if (if4.StallM !== 1'b0 || if4.ALUOutM !== 16'h0042 || if4.RD !== 16'h0) begin
            n_fail++; $display("FAIL lat4_alu_op: got stall=%b alu=%h rd=%h want 0/0042/0000", if4.StallM, if4.ALUOutM, if4.RD);
        end
        n_tests++; if (if4.RegWriteM !== 1'b1 || if4.WriteRegM !== 4'h7) begin
            n_fail++; $display("FAIL lat4_ctrl: got rw=%b wr=%h want 1/7", if4.RegWriteM, if4.WriteRegM);
        end
        @(negedge clk);
        access(1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0050, 16'hCAFE, 4'h0, st, rf, rl);
        n_tests++; if (st != 3) begin n_fail++; $display("FAIL lat4_store_stall: got %0d want 3", st); end
        access(1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0050, 16'h0, 4'h2, st, rf, rl);
        n_tests++; if (st != 3) begin n_fail++; $display("FAIL lat4_b2b_stall: got %0d want 3", st); end
        n_tests++; if (rf !== 16'h0 || rl !== 16'hCAFE) begin
            n_fail++; $display("FAIL lat4_load_rd: got first=%h final=%h want 0000/CAFE", rf, rl);
        end
        access(1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0051, 16'h0, 4'h0, st, rf, rl);
        n_tests++; if (rl !== 16'h00CA) begin n_fail++; $display("FAIL lat4_byte_load: got %h want 00CA", rl); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_flush();
        test_reset_mid();
        test_illegal();
        test_lat4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
